// File: rtl/anti_probe_cmp_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : anti_probe_pkg
// Description : Shared types and defaults for the anti-probe comparator
//               sampler: FSM state encoding, default channel count and
//               counter width, and the m_data slice-index helper.
//               Optional feature macro: CMP_SAMPLER_BASELINE_EN.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package anti_probe_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

  // Low bit of channel k inside the packed m_data word.
  function automatic int slice_lo(input int k, input int cnt_w);
    return k * cnt_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/anti_probe_cmp_sampler_cmp_chan_accum.sv
`default_nettype none
// ============================================================================
// Module      : cmp_chan_accum
// Description : One comparator channel: two-flop synchroniser, windowed
//               high-sample accumulator and sticky alarm compare.
//               With CMP_SAMPLER_BASELINE_EN the first window after each
//               accepted start is stored as a baseline and later windows
//               alarm on |result - baseline| > threshold.
// Ports       : clk, rst_n      - clock, async active-low reset
//               cmp_i          - raw comparator pad (asynchronous)
//               clear_i        - accepted start: clear acc (and baseline)
//               accum_en_i     - accumulate this cycle (FSM in ACCUM)
//               term_i         - terminal cycle of the current window
//               threshold_i    - latched alarm threshold
//               alarm_clr_i    - clear sticky alarm
//               result_o       - final window count (valid on term_i)
//               alarm_o        - sticky alarm
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_chan_accum #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmp_i,
  input  logic             clear_i,
  input  logic             accum_en_i,
  input  logic             term_i,
  input  logic [CNT_W-1:0] threshold_i,
  input  logic             alarm_clr_i,
  output logic [CNT_W-1:0] result_o,
  output logic             alarm_o
);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] s2_ext_w;
  logic             alarm_set_w;

  assign s2_ext_w = {{(CNT_W-1){1'b0}}, s2_q};
  // The terminal sample is folded in here so the result includes it while
  // the accumulator itself restarts on the same edge.
  assign result_o = acc_q + s2_ext_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= cmp_i;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (clear_i || term_i) begin
      acc_d = '0;
    end else if (accum_en_i) begin
      acc_d = acc_q + s2_ext_w;
    end
  end

`ifdef CMP_SAMPLER_BASELINE_EN
  logic [CNT_W-1:0] base_q, base_d;
  logic             base_vld_q, base_vld_d;
  logic [CNT_W:0]   diff_w;

  // Absolute difference in one extra bit so the subtraction cannot wrap.
  always_comb begin
    if (result_o >= base_q) begin
      diff_w = {1'b0, result_o} - {1'b0, base_q};
    end else begin
      diff_w = {1'b0, base_q} - {1'b0, result_o};
    end
  end

  always_comb begin
    base_d     = base_q;
    base_vld_d = base_vld_q;
    if (clear_i) begin
      base_d     = '0;
      base_vld_d = 1'b0;
    end else if (term_i && !base_vld_q) begin
      base_d     = result_o;
      base_vld_d = 1'b1;
    end
  end

  assign alarm_set_w = term_i && base_vld_q && (diff_w > {1'b0, threshold_i});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      base_vld_q <= 1'b0;
    end else begin
      base_q     <= base_d;
      base_vld_q <= base_vld_d;
    end
  end
`else
  assign alarm_set_w = term_i && (result_o > threshold_i);
`endif

  // Set has priority over clear so a same-cycle event is never lost.
  always_comb begin
    alarm_d = alarm_q;
    if (alarm_clr_i) alarm_d = 1'b0;
    if (alarm_set_w) alarm_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm_o = alarm_q;

endmodule
`default_nettype wire

// File: rtl/anti_probe_cmp_sampler.sv
`default_nettype none
// ============================================================================
// Module      : anti_probe_cmp_sampler
// Description : N-channel comparator sampler with windowed density counts
//               streamed over valid/ready and per-channel sticky alarms.
//               Holds the IDLE/ACCUM FSM, sample counter, output register
//               and overrun flag. Optional macro: CMP_SAMPLER_BASELINE_EN.
// Ports       : sample_clk, sample_rst_n - clock, async active-low reset
//               cmp_data_in  - raw comparator pads
//               start, stop  - begin / end continuous accumulation
//               win_len, threshold - latched on accepted start
//               m_valid, m_ready, m_data - result stream
//               alarm, alarm_clr - sticky alarms and their clear
//               busy         - FSM in ACCUM
//               overrun      - sticky, a result was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module anti_probe_cmp_sampler
  import anti_probe_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    sample_clk,
  input  logic                    sample_rst_n,
  input  logic [NUM_CH-1:0]       cmp_data_in,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_W-1:0]        win_len,
  input  logic [CNT_W-1:0]        threshold,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NUM_CH*CNT_W-1:0] m_data,
  output logic [NUM_CH-1:0]       alarm,
  input  logic                    alarm_clr,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          samp_cnt_q, samp_cnt_d;
  logic [CNT_W-1:0]          win_len_q, win_len_d;
  logic [CNT_W-1:0]          threshold_q, threshold_d;
  logic                      m_valid_q, m_valid_d;
  logic [NUM_CH*CNT_W-1:0]   m_data_q, m_data_d;
  logic                      overrun_q, overrun_d;

  logic                      start_acc_w;
  logic                      term_w;
  logic                      accum_w;
  logic                      load_w;
  logic [NUM_CH*CNT_W-1:0]   result_w;

  assign accum_w     = (state_q == ACCUM);
  // stop beats start when both arrive together.
  assign start_acc_w = (state_q == IDLE) && start && !stop && (win_len != '0);
  // A stop on the terminal cycle discards that window like any other.
  assign term_w      = accum_w && !stop && (samp_cnt_q == (win_len_q - C_ONE));
  assign load_w      = term_w && (!m_valid_q || m_ready);

  // FSM next state and counter/config registers.
  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    win_len_d   = win_len_q;
    threshold_d = threshold_q;
    case (state_q)
      IDLE: begin
        if (start_acc_w) begin
          state_d     = ACCUM;
          samp_cnt_d  = '0;
          win_len_d   = win_len;
          threshold_d = threshold;
        end
      end
      ACCUM: begin
        if (stop) begin
          state_d = IDLE;
        end else if (term_w) begin
          samp_cnt_d = '0;
        end else begin
          samp_cnt_d = samp_cnt_q + C_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register and overrun.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    overrun_d = overrun_q;
    if (load_w) begin
      m_valid_d = 1'b1;
      m_data_d  = result_w;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    if (alarm_clr) overrun_d = 1'b0;
    if (term_w && !load_w) overrun_d = 1'b1;
  end

  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      state_q     <= IDLE;
      samp_cnt_q  <= '0;
      win_len_q   <= '0;
      threshold_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      win_len_q   <= win_len_d;
      threshold_q <= threshold_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      overrun_q   <= overrun_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    localparam int LO = slice_lo(k, CNT_W);
    cmp_chan_accum #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk         (sample_clk),
      .rst_n       (sample_rst_n),
      .cmp_i       (cmp_data_in[k]),
      .clear_i     (start_acc_w),
      .accum_en_i  (accum_w),
      .term_i      (term_w),
      .threshold_i (threshold_q),
      .alarm_clr_i (alarm_clr),
      .result_o    (result_w[LO +: CNT_W]),
      .alarm_o     (alarm[k])
    );
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = accum_w;
  assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: doc/anti_probe_cmp_sampler.md
# anti_probe_cmp_sampler

N-channel comparator sampling and windowed-density block for the anti-probe front end. It supersedes the fixed three-pad, single-register capture with a parametrised channel count and a two-flop synchroniser per pad. Each channel counts comparator-high samples over a programmable window and emits the per-channel counts through a valid/ready stream. A per-channel alarm compares the counts against a threshold. It sits between the AnalogCMP instances and the wrapper that packs words into GTH_DATA.

## Interface
- NUM_CH, 4: number of comparator channels (1..16).
- CNT_W, 16: counter and window width; max window 2^CNT_W-1 samples.
- sample_clk  in  1  sampling clock; the single clock of the block.
- sample_rst_n  in  1  asynchronous, active-low reset.
- cmp_data_in  in  NUM_CH  raw comparator outputs (asynchronous to sample_clk).
- start  in  1  pulse; begins continuous windowed accumulation.
- stop  in  1  pulse; ends accumulation.
- win_len  in  CNT_W  window length in samples; sampled on accepted start.
- threshold  in  CNT_W  alarm threshold; sampled on accepted start.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  NUM_CH*CNT_W  per-channel counts; channel k at bits [k*CNT_W +: CNT_W].
- alarm  out  NUM_CH  sticky per-channel alarm.
- alarm_clr  in  1  clears all alarm bits.
- busy  out  1  high in ACCUM.
- overrun  out  1  sticky; a result was dropped. Cleared by alarm_clr.

## Operation
- Reset values: m_valid=0, m_data=0, alarm=0, busy=0, overrun=0, state IDLE, all counters 0, synchroniser flops 0.
- Synchroniser: cmp_data_in passes through two flops, s1 then s2. Only s2 is used.
- FSM states and transitions:
  - IDLE: start with win_len!=0 -> ACCUM. Latch win_len and threshold, clear the sample counter and the accumulators. start with win_len==0 is ignored.
  - ACCUM: each cycle samp_cnt increments and acc[k] += s2[k].
  - On samp_cnt==win_len_q-1 (terminal cycle), result[k] = acc[k]+s2[k]. On the same edge, samp_cnt and acc clear and the next window begins. There are no dead cycles between windows.
  - stop -> IDLE on the next edge. The partial window is discarded. A pending m_valid result is kept.
  - start while in ACCUM is ignored. start and stop in the same cycle: stop wins.
- Output register, on the terminal cycle:
  - If m_valid==0, or m_valid&&m_ready in that cycle: load m_data and set m_valid.
  - Otherwise: drop the new result, keep the old m_data, set overrun.
  - m_valid clears on m_valid&&m_ready when no load occurs.
- Alarm is evaluated on the terminal cycle against the final count, regardless of whether the result is dropped.
  - Default rule: alarm[k] sets if result[k] > threshold_q.
  - alarm_clr clears alarm and overrun. A set in the same cycle as alarm_clr wins.
- Counts are unsigned. result[k] <= win_len_q < 2^CNT_W, so no overflow occurs.

## Timing
- Pad-to-count latency: 2 cycles through the synchroniser. A pad edge at cycle t affects acc from the t+2 sample.
- Terminal cycle to m_valid, m_data and alarm: 1 edge, all registered together.
- Window period is exactly win_len_q cycles. win_len=1 produces a result every cycle.
- Reset asserted mid-window: everything returns to reset values asynchronously. No result is produced.
- m_data is stable while m_valid && !m_ready.

## Configuration
- CMP_SAMPLER_BASELINE_EN defined:
  - The first completed window after each accepted start is stored as baseline[k] and output normally. It never sets alarm.
  - Later windows set alarm[k] if |result[k]-baseline[k]| > threshold_q. The absolute difference is computed in CNT_W+1 bits.
  - The baseline is cleared on reset and on each accepted start.
- Not defined: no baseline registers. The absolute rule result[k] > threshold_q applies to every window.

## Structure
- Package anti_probe_pkg holds:
  - the FSM state enum (IDLE, ACCUM);
  - the default NUM_CH and CNT_W localparams;
  - a function returning the m_data slice index.
- Sub-module cmp_chan_accum, generated NUM_CH times, contains the synchroniser, the accumulator, the baseline register under the macro, and the alarm compare.
- The top level holds the FSM, samp_cnt, the output register and overrun.

## Test plan
- NUM_CH=4, win_len=8, threshold=5, pads held at 4'b0101, m_ready=1 -> m_valid every 8 cycles with m_data counts {0,8,0,8}. alarm=4'b0101 from the first result.
- win_len=4, m_ready=0 for 10 windows -> first result held, overrun=1 after the 2nd terminal cycle, m_data unchanged. alarm_clr -> overrun=0.
- stop at sample 3 of win_len=10 -> no result, busy=0 next cycle. A pending result is still delivered when m_ready rises.
- start with win_len=0 -> stays IDLE, busy=0. start and stop in the same cycle -> IDLE.
- Reset pulse mid-window with m_valid=1 -> m_valid=0, alarm=0 and all outputs at reset values immediately.
- With CMP_SAMPLER_BASELINE_EN, win_len=16, threshold=2: baseline count 8, next count 11 -> alarm set. Count 10 -> no alarm.
